// File: rtl/rv32i_pkg.sv
// rv32i_pkg
// Shared definitions for the decode/execute operand stage and its register
// file.
//
// Contents:
//   - XLEN and NREGS: default datapath width and register count.
//   - REG_AW: register address width.
//   - fs_e: the execute-stage function-select encodings.
//   - FS_BUBBLE: the function select loaded for a bubble.
//   - is_legal_fs(): returns 1 when a 4-bit code is one of the legal
//     function selects.
package rv32i_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  typedef enum logic [3:0] {
    FS_ADD  = 4'b0000,
    FS_SUB  = 4'b0001,
    FS_SLL  = 4'b0010,
    FS_SLT  = 4'b0100,
    FS_SLTU = 4'b0110,
    FS_XOR  = 4'b1000,
    FS_SRL  = 4'b1010,
    FS_SRA  = 4'b1011,
    FS_OR   = 4'b1100,
    FS_AND  = 4'b1110
  } fs_e;

  // A bubble looks like an ADD that writes nothing.
  localparam logic [3:0] FS_BUBBLE = FS_ADD;

  function automatic logic is_legal_fs(input logic [3:0] fs);
    case (fs)
      FS_ADD, FS_SUB, FS_SLL, FS_SLT, FS_SLTU,
      FS_XOR, FS_SRL, FS_SRA, FS_OR, FS_AND: is_legal_fs = 1'b1;
      default:                               is_legal_fs = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
// Architectural register file with two combinational read ports and one
// write port. Entry 0 is hardwired to zero: writes to it are dropped, and
// reads of it return zero.
//
// Optional build macro: RF_BYPASS_EN
//   - Defined: a read of the register being written this cycle returns the
//     incoming wb_data (write-through).
//   - Undefined: such a read returns the old entry. The new value becomes
//     visible on the following cycle.
//
// Ports:
//   clk, rst           rising-edge clock; async active-high reset that
//                      clears every entry
//   rs1_addr, rs2_addr read addresses
//   rs1_data, rs2_data combinational read data
//   wb_en              write-back enable
//   wb_addr, wb_data   write-back address and data
//
// NREGS is expected to be a power of two, so every address decodes to a
// real entry.
module regfile_2r1w #(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int NREGS = rv32i_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  logic            wb_hit_valid;

  // A write to x0 is treated as no write at all.
  assign wb_hit_valid = wb_en && (wb_addr != '0);

  // Next-state for the array: only the addressed entry changes.
  always_comb begin
    rf_d = rf_q;
    if (wb_hit_valid) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports. x0 is forced to zero here as well, so that the bypass
  // path can never return a value for x0.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 : rf_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 : rf_q[rs2_addr];
`ifdef RF_BYPASS_EN
    if (wb_hit_valid && (wb_addr == rs1_addr)) begin
      rs1_data = wb_data;
    end
    if (wb_hit_valid && (wb_addr == rs2_addr)) begin
      rs2_data = wb_data;
    end
`endif
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// Decode-to-execute pipeline stage. Each cycle it:
//   - reads rs1 and rs2 from the register file;
//   - selects either the immediate or R[rs2] for operand B;
//   - registers the operands and control into the ID/EX register.
// It also takes the write-back port from later stages. The register file is
// never stalled.
//
// Optional build macro: RF_BYPASS_EN (see regfile_2r1w). When defined, a
// write-back in the same cycle is visible to the operand reads.
//
// Ports:
//   clk, rst                 rising-edge clock; async active-high reset
//   valid_in                 a decoded instruction is present this cycle
//   rs1, rs2, rd_in          source and destination register addresses
//   imm, use_imm             immediate value and B-operand select
//   fs_in, reg_write_in      function select and write-back request
//   stall, flush             hazard control (flush has priority)
//   wb_en, wb_addr, wb_data  write-back port into the register file
//   A, B, FS, rd_out         registered operands and control
//   reg_write_out            registered write enable (0 for bubbles and
//                            for illegal function selects)
//   valid_out                registered valid
//   illegal_fs               registered: the loaded fs_in was not legal
//
// Edge priority: rst > flush > stall > load.
module id_ex_operand_stage #(
  parameter int XLEN  = rv32i_pkg::XLEN,
  parameter int NREGS = rv32i_pkg::NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd_in,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic [3:0]      fs_in,
  input  logic            reg_write_in,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      FS,
  output logic [AW-1:0]   rd_out,
  output logic            reg_write_out,
  output logic            valid_out,
  output logic            illegal_fs
);

  import rv32i_pkg::*;

  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] b_sel;
  logic            fs_ok;

  logic [XLEN-1:0] a_q,  a_d;
  logic [XLEN-1:0] b_q,  b_d;
  logic [3:0]      fs_q, fs_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            valid_q, valid_d;
  logic            illegal_q, illegal_d;

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rf_a),
    .rs2_data (rf_b),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  assign b_sel = use_imm ? imm : rf_b;
  assign fs_ok = is_legal_fs(fs_in);

  // ID/EX next-state.
  //   - flush, or no valid instruction: load a bubble.
  //   - stall: the register holds its value.
  //   - illegal fs_in: still counts as a valid instruction, but it is
  //     defused into an ADD that writes nothing, with illegal_fs raised.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    fs_d        = fs_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    valid_d     = valid_q;
    illegal_d   = illegal_q;
    if (flush || (!stall && !valid_in)) begin
      a_d         = '0;
      b_d         = '0;
      fs_d        = FS_BUBBLE;
      rd_d        = '0;
      reg_write_d = 1'b0;
      valid_d     = 1'b0;
      illegal_d   = 1'b0;
    end else if (!stall) begin
      a_d         = rf_a;
      b_d         = b_sel;
      rd_d        = rd_in;
      valid_d     = 1'b1;
      fs_d        = fs_ok ? fs_in : FS_BUBBLE;
      reg_write_d = fs_ok && reg_write_in;
      illegal_d   = !fs_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q         <= '0;
      b_q         <= '0;
      fs_q        <= FS_BUBBLE;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      fs_q        <= fs_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      valid_q     <= valid_d;
      illegal_q   <= illegal_d;
    end
  end

  assign A             = a_q;
  assign B             = b_q;
  assign FS            = fs_q;
  assign rd_out        = rd_q;
  assign reg_write_out = reg_write_q;
  assign valid_out     = valid_q;
  assign illegal_fs    = illegal_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
// Scoreboard bench for id_ex_operand_stage.
//
// Structure:
//   - The driver applies one stimulus set per cycle on the falling edge.
//   - For each stimulus set it works out, from a plain array model of the
//     register file, what the ID/EX register must hold after the next
//     rising edge, and queues that expectation.
//   - The monitor pops one expectation every cycle, just after the rising
//     edge, and compares it with the DUT outputs.
//
// The RF_BYPASS_EN macro selects which read behaviour the model expects.
module tb_id_ex_operand_stage;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        stall;
    logic        flush;
    logic        use_imm;
    logic        reg_write;
    logic        wb_en;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [4:0]  wb_addr;
    logic [31:0] imm;
    logic [31:0] wb_data;
    logic [3:0]  fs;
  } stim_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  fs;
    logic [4:0]  rd;
    logic        rw;
    logic        valid;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd_in;
  logic [31:0] imm;
  logic        use_imm;
  logic [3:0]  fs_in;
  logic        reg_write_in;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  FS;
  logic [4:0]  rd_out;
  logic        reg_write_out;
  logic        valid_out;
  logic        illegal_fs;

  logic [31:0] model_rf [32];
  logic [3:0]  legal_list [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6,
                                   4'h8, 4'hA, 4'hB, 4'hC, 4'hE};
  exp_t        exp_q [$];
  exp_t        prev_exp;
  int          check_count = 0;
  int          pass_count  = 0;
  int          cycle_no    = 0;

  id_ex_operand_stage dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd_in         (rd_in),
    .imm           (imm),
    .use_imm       (use_imm),
    .fs_in         (fs_in),
    .reg_write_in  (reg_write_in),
    .stall         (stall),
    .flush         (flush),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .A             (A),
    .B             (B),
    .FS            (FS),
    .rd_out        (rd_out),
    .reg_write_out (reg_write_out),
    .valid_out     (valid_out),
    .illegal_fs    (illegal_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic logic isLegal(input logic [3:0] f);
    foreach (legal_list[i]) if (legal_list[i] == f) return 1'b1;
    return 1'b0;
  endfunction

  // Register read as seen by the decode stage in the cycle of stimulus s.
  function automatic logic [31:0] modelRead(input logic [4:0] r, input stim_t s);
    if (r == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
    if (s.wb_en && s.wb_addr == r) return s.wb_data;
`endif
    return model_rf[r];
  endfunction

  // Drive one cycle of stimulus and queue what the ID/EX register must
  // hold after the following rising edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    @(negedge clk);
    rst          = s.rst;
    valid_in     = s.valid;
    stall        = s.stall;
    flush        = s.flush;
    use_imm      = s.use_imm;
    reg_write_in = s.reg_write;
    wb_en        = s.wb_en;
    rs1          = s.rs1;
    rs2          = s.rs2;
    rd_in        = s.rd;
    wb_addr      = s.wb_addr;
    imm          = s.imm;
    wb_data      = s.wb_data;
    fs_in        = s.fs;
    e = '0;
    if (s.rst) begin
      foreach (model_rf[i]) model_rf[i] = 32'd0;
    end else begin
      if (s.flush || !s.valid) begin
        e = '0;
        if (s.stall && !s.flush) e = prev_exp;
      end else if (s.stall) begin
        e = prev_exp;
      end else begin
        e.a     = modelRead(s.rs1, s);
        e.b     = s.use_imm ? s.imm : modelRead(s.rs2, s);
        e.rd    = s.rd;
        e.valid = 1'b1;
        if (isLegal(s.fs)) begin
          e.fs  = s.fs;
          e.rw  = s.reg_write;
          e.ill = 1'b0;
        end else begin
          e.fs  = 4'h0;
          e.rw  = 1'b0;
          e.ill = 1'b1;
        end
      end
      if (s.wb_en && s.wb_addr != 5'd0) model_rf[s.wb_addr] = s.wb_data;
    end
    prev_exp = e;
    exp_q.push_back(e);
    cycle_no++;
  endtask

  task automatic checkOutput(input exp_t e);
    exp_t act;
    act = '{a: A, b: B, fs: FS, rd: rd_out, rw: reg_write_out,
            valid: valid_out, ill: illegal_fs};
    check_count++;
    if (act === e) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL idex_regs t=%0t got A=%h B=%h FS=%h rd=%0d rw=%b v=%b ill=%b, expected A=%h B=%h FS=%h rd=%0d rw=%b v=%b ill=%b",
               $time, act.a, act.b, act.fs, act.rd, act.rw, act.valid, act.ill,
               e.a, e.b, e.fs, e.rd, e.rw, e.valid, e.ill);
    end
  endtask

  // Monitor: one ID/EX update per rising edge, checked 1 ns later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end
  end

  function automatic stim_t randomStim();
    stim_t s;
    s = idle();
    s.valid     = ($urandom_range(0, 9) < 8);
    s.stall     = ($urandom_range(0, 99) < 15);
    s.flush     = ($urandom_range(0, 99) < 8);
    s.use_imm   = 1'($urandom_range(0, 1));
    s.reg_write = 1'($urandom_range(0, 1));
    s.wb_en     = 1'($urandom_range(0, 1));
    s.rs1       = 5'($urandom_range(0, 31));
    s.rs2       = 5'($urandom_range(0, 31));
    s.rd        = 5'($urandom_range(0, 31));
    s.wb_addr   = 5'($urandom_range(0, 31));
    s.imm       = $urandom;
    s.wb_data   = $urandom;
    if ($urandom_range(0, 3) != 0) s.fs = legal_list[$urandom_range(0, 9)];
    else                           s.fs = 4'($urandom_range(0, 15));
    return s;
  endfunction

  initial begin
    stim_t s;
    rst = 1'b1; valid_in = 1'b0; stall = 1'b0; flush = 1'b0; use_imm = 1'b0;
    reg_write_in = 1'b0; wb_en = 1'b0; rs1 = '0; rs2 = '0; rd_in = '0;
    wb_addr = '0; imm = '0; wb_data = '0; fs_in = '0;
    prev_exp = '0;
    foreach (model_rf[i]) model_rf[i] = 32'd0;

    // Power-on reset.
    s = idle(); s.rst = 1'b1;
    applyStimulus(s);
    applyStimulus(s);

    // Some random traffic, then a mid-run reset with busy inputs.
    for (int i = 0; i < 20; i++) applyStimulus(randomStim());
    s = randomStim(); s.rst = 1'b1; s.valid = 1'b1; s.wb_en = 1'b1; s.wb_addr = 5'd9;
    applyStimulus(s);
    applyStimulus(s);

    // Write R5 = 0xAA, then read it back through A.
    s = idle(); s.wb_en = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'h0000_00AA;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd0; s.fs = 4'b0000;
    applyStimulus(s);

    // x0 protection.
    s = idle(); s.wb_en = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'hFFFF_FFFF;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd0; s.rs2 = 5'd0;
    applyStimulus(s);

    // Immediate select with SRA.
    s = idle(); s.wb_en = 1'b1; s.wb_addr = 5'd3; s.wb_data = 32'd7;
    applyStimulus(s);
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd3; s.use_imm = 1'b1;
    s.imm = 32'hFFFF_FFF0; s.fs = 4'b1011; s.rd = 5'd2; s.reg_write = 1'b1;
    applyStimulus(s);

    // Same-cycle write and read of R9, then re-issue the read.
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd9; s.rs2 = 5'd9;
    s.wb_en = 1'b1; s.wb_addr = 5'd9; s.wb_data = 32'h0000_1234;
    applyStimulus(s);
    s.wb_en = 1'b0;
    applyStimulus(s);

    // Load, stall three cycles (with a write to a source), then stall+flush.
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd5; s.rs2 = 5'd3; s.rd = 5'd7;
    s.reg_write = 1'b1; s.fs = 4'b0001;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = randomStim(); s.stall = 1'b1; s.flush = 1'b0;
      s.wb_en = 1'b1; s.wb_addr = 5'd5;
      applyStimulus(s);
    end
    s = randomStim(); s.valid = 1'b1; s.stall = 1'b1; s.flush = 1'b1;
    applyStimulus(s);

    // Illegal function select, then a legal one.
    s = idle(); s.valid = 1'b1; s.rs1 = 5'd3; s.rs2 = 5'd5; s.rd = 5'd4;
    s.reg_write = 1'b1; s.fs = 4'b0011;
    applyStimulus(s);
    s.fs = 4'b1100;
    applyStimulus(s);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) applyStimulus(randomStim());

    // Drain the scoreboard.
    @(posedge clk);
    #3;
    check_count++;
    if (exp_q.size() == 0) pass_count++;
    else $display("[TB] FAIL scoreboard_drain got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
